// File: rtl/adma_dm_rd_host.sv
// AXI4 read host of the DMA data mover: AR issue, in-order outstanding tracking, R forwarding.
// Optional ADMA_DM_RD_ZERO_ON_ERR_EN zeroes forwarded data on beats with bad RRESP or RID.
module adma_dm_rd_host #(
    parameter int DMA_CHN_NUM    = 4,
    parameter int SRC_ADDR_W     = 32,
    parameter int MST_ID_W       = 5,
    parameter int ATX_LEN_W      = 8,
    parameter int ATX_RESP_W     = 2,
    parameter int ATX_SRC_DATA_W = 256,
    parameter int ATX_NUM_OSTD   = DMA_CHN_NUM,
    parameter int DMA_CHN_NUM_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DMA_CHN_NUM_W-1:0]  atx_chn_id,
    input  logic [MST_ID_W-1:0]       atx_arid,
    input  logic [SRC_ADDR_W-1:0]     atx_araddr,
    input  logic [ATX_LEN_W-1:0]      atx_arlen,
    input  logic [1:0]                atx_arburst,
    input  logic                      atx_vld,
    output logic                      atx_rdy,
    output logic [ATX_SRC_DATA_W-1:0] atx_rdata,
    output logic                      atx_rdata_vld,
    input  logic                      atx_rdata_rdy,
    output logic [DMA_CHN_NUM-1:0]    atx_done,
    output logic [DMA_CHN_NUM-1:0]    atx_src_err,
    output logic [MST_ID_W-1:0]       m_arid_o,
    output logic [SRC_ADDR_W-1:0]     m_araddr_o,
    output logic [ATX_LEN_W-1:0]      m_arlen_o,
    output logic [1:0]                m_arburst_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [MST_ID_W-1:0]       m_rid_i,
    input  logic [ATX_SRC_DATA_W-1:0] m_rdata_i,
    input  logic [ATX_RESP_W-1:0]     m_rresp_i,
    input  logic                      m_rlast_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o
);

    localparam int PTR_W = $clog2(ATX_NUM_OSTD);

    logic                     arvalid_q, arvalid_d;
    logic [MST_ID_W-1:0]      arid_q, arid_d;
    logic [SRC_ADDR_W-1:0]    araddr_q, araddr_d;
    logic [ATX_LEN_W-1:0]     arlen_q, arlen_d;
    logic [1:0]               arburst_q, arburst_d;

    logic [DMA_CHN_NUM_W-1:0] fifo_chn_q [ATX_NUM_OSTD];
    logic [MST_ID_W-1:0]      fifo_id_q  [ATX_NUM_OSTD];
    logic [ATX_LEN_W-1:0]     fifo_len_q [ATX_NUM_OSTD];
    logic [PTR_W:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]           rd_ptr_q, rd_ptr_d;

    logic [ATX_LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                     err_q, err_d;
    logic [DMA_CHN_NUM-1:0]   done_q, done_d;
    logic [DMA_CHN_NUM-1:0]   serr_q, serr_d;

    logic                     ostd_empty, ostd_full;
    logic                     push, pop, beat_acc, last_beat;
    logic                     resp_err, id_err, beat_err;
    logic [DMA_CHN_NUM_W-1:0] head_chn;
    logic [MST_ID_W-1:0]      head_id;
    logic [ATX_LEN_W-1:0]     head_len;
    logic [DMA_CHN_NUM-1:0]   chn_oh;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign ostd_empty = (wr_ptr_q == rd_ptr_q);
    assign ostd_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign head_chn = fifo_chn_q[rd_ptr_q[PTR_W-1:0]];
    assign head_id  = fifo_id_q[rd_ptr_q[PTR_W-1:0]];
    assign head_len = fifo_len_q[rd_ptr_q[PTR_W-1:0]];
    assign chn_oh   = DMA_CHN_NUM'(1) << head_chn;

    assign atx_rdy = (~arvalid_q | m_arready_i) & ~ostd_full;
    assign push    = atx_vld & atx_rdy;

    assign m_rready_o    = atx_rdata_rdy & ~ostd_empty;
    assign atx_rdata_vld = m_rvalid_i & ~ostd_empty;
    assign beat_acc      = m_rvalid_i & m_rready_o;

    // Burst end comes from the beat count alone; RLAST is only checked
    assign last_beat = (beat_cnt_q == head_len);
    assign resp_err  = (m_rresp_i != '0);
    assign id_err    = (m_rid_i != head_id);
    assign beat_err  = resp_err | id_err | (m_rlast_i != last_beat);
    assign pop       = beat_acc & last_beat;

`ifdef ADMA_DM_RD_ZERO_ON_ERR_EN
    assign atx_rdata = (resp_err | id_err) ? '0 : m_rdata_i;
`else
    assign atx_rdata = m_rdata_i;
`endif

    assign m_arvalid_o = arvalid_q;
    assign m_arid_o    = arid_q;
    assign m_araddr_o  = araddr_q;
    assign m_arlen_o   = arlen_q;
    assign m_arburst_o = arburst_q;
    assign atx_done    = done_q;
    assign atx_src_err = serr_q;

    always_comb begin
        arvalid_d  = arvalid_q;
        arid_d     = arid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arburst_d  = arburst_q;
        wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        done_d     = '0;
        serr_d     = '0;

        if (m_arready_i) begin
            arvalid_d = 1'b0;
        end
        if (push) begin
            arvalid_d = 1'b1;
            arid_d    = atx_arid;
            araddr_d  = atx_araddr;
            arlen_d   = atx_arlen;
            arburst_d = atx_arburst;
        end

        if (beat_acc) begin
            if (last_beat) begin
                beat_cnt_d = '0;
                err_d      = 1'b0;
                done_d     = chn_oh;
                serr_d     = (err_q | beat_err) ? chn_oh : '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                err_d      = err_q | beat_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q  <= 1'b0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arburst_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= '0;
            serr_q     <= '0;
        end else begin
            arvalid_q  <= arvalid_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arburst_q  <= arburst_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            serr_q     <= serr_d;
        end
    end

    // Entry storage needs no reset: the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_chn_q[wr_ptr_q[PTR_W-1:0]] <= atx_chn_id;
            fifo_id_q[wr_ptr_q[PTR_W-1:0]]  <= atx_arid;
            fifo_len_q[wr_ptr_q[PTR_W-1:0]] <= atx_arlen;
        end
    end

endmodule

// File: tb/tb_adma_dm_rd_host.sv
// Self-checking bench for adma_dm_rd_host: directed table, corner sequences, random bursts.
module tb_adma_dm_rd_host;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int IW   = 5;
    localparam int LW   = 8;
    localparam int DW   = 256;
    localparam int OSTD = 4;
    localparam int CW   = 2;

    localparam int K_NONE  = 0;
    localparam int K_RESP  = 1;
    localparam int K_ID    = 2;
    localparam int K_EARLY = 3;
    localparam int K_MISS  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] atx_chn_id = '0;
    logic [IW-1:0] atx_arid = '0;
    logic [AW-1:0] atx_araddr = '0;
    logic [LW-1:0] atx_arlen = '0;
    logic [1:0]    atx_arburst = '0;
    logic          atx_vld = 1'b0;
    logic          atx_rdy;
    logic [DW-1:0] atx_rdata;
    logic          atx_rdata_vld;
    logic          atx_rdata_rdy = 1'b0;
    logic [N-1:0]  atx_done;
    logic [N-1:0]  atx_src_err;
    logic [IW-1:0] m_arid_o;
    logic [AW-1:0] m_araddr_o;
    logic [LW-1:0] m_arlen_o;
    logic [1:0]    m_arburst_o;
    logic          m_arvalid_o;
    logic          m_arready_i = 1'b0;
    logic [IW-1:0] m_rid_i = '0;
    logic [DW-1:0] m_rdata_i = '0;
    logic [1:0]    m_rresp_i = '0;
    logic          m_rlast_i = 1'b0;
    logic          m_rvalid_i = 1'b0;
    logic          m_rready_o;

    always #5 clk = ~clk;

    adma_dm_rd_host dut (
        .clk           (clk),
        .rst           (rst),
        .atx_chn_id    (atx_chn_id),
        .atx_arid      (atx_arid),
        .atx_araddr    (atx_araddr),
        .atx_arlen     (atx_arlen),
        .atx_arburst   (atx_arburst),
        .atx_vld       (atx_vld),
        .atx_rdy       (atx_rdy),
        .atx_rdata     (atx_rdata),
        .atx_rdata_vld (atx_rdata_vld),
        .atx_rdata_rdy (atx_rdata_rdy),
        .atx_done      (atx_done),
        .atx_src_err   (atx_src_err),
        .m_arid_o      (m_arid_o),
        .m_araddr_o    (m_araddr_o),
        .m_arlen_o     (m_arlen_o),
        .m_arburst_o   (m_arburst_o),
        .m_arvalid_o   (m_arvalid_o),
        .m_arready_i   (m_arready_i),
        .m_rid_i       (m_rid_i),
        .m_rdata_i     (m_rdata_i),
        .m_rresp_i     (m_rresp_i),
        .m_rlast_i     (m_rlast_i),
        .m_rvalid_i    (m_rvalid_i),
        .m_rready_o    (m_rready_o)
    );

    typedef struct {
        logic [CW-1:0] chn;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [1:0]    bst;
        int            kind;
        int            eb;
        int            tag;
    } req_t;

    typedef struct {
        req_t         r;
        logic [N-1:0] done;
        logic [N-1:0] err;
    } vec_t;

    req_t send_q[$];
    req_t os[$];
    int nar, bidx, nchk, nerr, beats, tagc;
    int p_vld, p_ar, p_rdy, p_rv;
    bit ar_pend, rv_hold, tog;
    logic [N-1:0] got_done, got_err;

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit pct(int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic req_t mk(int c, int id, int a, int l, int k, int e);
        req_t r;
        r.chn  = CW'(c);
        r.id   = IW'(id);
        r.addr = AW'(a);
        r.len  = LW'(l);
        r.bst  = 2'b01;
        r.kind = k;
        r.eb   = e;
        tagc++;
        r.tag  = tagc;
        return r;
    endfunction

    function automatic logic [DW-1:0] bdata(req_t r, int b);
        logic [31:0] w;
        w = 32'(r.tag * 256 + b);
        return {8{w}};
    endfunction

    function automatic logic [DW-1:0] exp_data(req_t r, int b);
`ifdef ADMA_DM_RD_ZERO_ON_ERR_EN
        if ((r.kind == K_RESP || r.kind == K_ID) && b == r.eb) return '0;
`endif
        return bdata(r, b);
    endfunction

    // One clock: drive at negedge, check combinational outputs, step model, check registered outputs
    task automatic cycle();
        bit a_req, a_ar, a_r, rdy_e, rr_e;
        logic [N-1:0] ed, ee;
        req_t h;
        atx_vld = send_q.size() > 0 && pct(p_vld);
        if (send_q.size() > 0) begin
            atx_chn_id  = send_q[0].chn;
            atx_arid    = send_q[0].id;
            atx_araddr  = send_q[0].addr;
            atx_arlen   = send_q[0].len;
            atx_arburst = send_q[0].bst;
        end
        m_arready_i   = pct(p_ar);
        atx_rdata_rdy = tog ? ~atx_rdata_rdy : pct(p_rdy);
        m_rvalid_i    = rv_hold || (nar > 0 && pct(p_rv));
        if (nar > 0) begin
            h = os[0];
            m_rid_i   = (h.kind == K_ID && bidx == h.eb) ? ~h.id : h.id;
            m_rresp_i = (h.kind == K_RESP && bidx == h.eb) ? 2'b10 : 2'b00;
            m_rlast_i = (bidx == int'(h.len)) ^
                        ((h.kind == K_EARLY || h.kind == K_MISS) && bidx == h.eb);
            m_rdata_i = bdata(h, bidx);
        end else begin
            m_rid_i   = '0;
            m_rresp_i = '0;
            m_rlast_i = 1'b0;
            m_rdata_i = '0;
        end
        #1;
        rdy_e = (!ar_pend || m_arready_i) && os.size() < OSTD;
        rr_e  = atx_rdata_rdy && os.size() > 0;
        chk("atx_rdy", atx_rdy, rdy_e);
        chk("rready", m_rready_o, rr_e);
        chk("rdata_vld", atx_rdata_vld, m_rvalid_i && os.size() > 0);
        if (m_rvalid_i && m_rready_o) beats++;
        a_req   = atx_vld && rdy_e;
        a_ar    = ar_pend && m_arready_i;
        a_r     = m_rvalid_i && rr_e;
        rv_hold = m_rvalid_i && !a_r;
        ed = '0;
        ee = '0;
        if (a_r) begin
            chk("rdata", atx_rdata, exp_data(os[0], bidx));
            if (bidx == int'(os[0].len)) begin
                ed[os[0].chn] = 1'b1;
                ee[os[0].chn] = (os[0].kind != K_NONE);
                void'(os.pop_front());
                nar--;
                bidx = 0;
            end else begin
                bidx++;
            end
        end
        if (a_ar) begin
            ar_pend = 1'b0;
            nar++;
        end
        if (a_req) begin
            os.push_back(send_q.pop_front());
            ar_pend = 1'b1;
        end
        @(negedge clk);
        chk("done", atx_done, ed);
        chk("src_err", atx_src_err, ee);
        chk("arvalid", m_arvalid_o, ar_pend);
        if (ar_pend) begin
            chk("arid", m_arid_o, os[nar].id);
            chk("araddr", m_araddr_o, os[nar].addr);
            chk("arlen", m_arlen_o, os[nar].len);
            chk("arburst", m_arburst_o, os[nar].bst);
        end
        if (ed != '0) begin
            got_done = ed;
            got_err  = ee;
        end
    endtask

    task automatic run_idle(int budget);
        int n;
        n = 0;
        while ((send_q.size() > 0 || os.size() > 0 || ar_pend) && n < budget) begin
            cycle();
            n++;
        end
        if (send_q.size() > 0 || os.size() > 0 || ar_pend) begin
            nchk++;
            nerr++;
            $display("FAIL timeout: still busy after %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        atx_vld       = 1'b0;
        m_arready_i   = 1'b0;
        atx_rdata_rdy = 1'b1;
        m_rvalid_i    = 1'b1;
        m_rid_i       = '0;
        m_rresp_i     = '0;
        m_rlast_i     = 1'b0;
        @(negedge clk);
        chk("rst_arvalid", m_arvalid_o, 0);
        chk("rst_arid", m_arid_o, 0);
        chk("rst_araddr", m_araddr_o, 0);
        chk("rst_arlen", m_arlen_o, 0);
        chk("rst_arburst", m_arburst_o, 0);
        chk("rst_done", atx_done, 0);
        chk("rst_err", atx_src_err, 0);
        chk("rst_rready", m_rready_o, 0);
        chk("rst_rdata_vld", atx_rdata_vld, 0);
        chk("rst_rdy", atx_rdy, 1);
        rst        = 1'b0;
        m_rvalid_i = 1'b0;
        send_q.delete();
        os.delete();
        nar     = 0;
        bidx    = 0;
        ar_pend = 1'b0;
        rv_hold = 1'b0;
    endtask

    initial begin
        vec_t tv[7];
        int n, k, l, e;
        nchk = 0; nerr = 0; beats = 0; tagc = 0;
        p_vld = 100; p_ar = 100; p_rdy = 100; p_rv = 100;
        tog = 1'b0;
        got_done = '0;
        got_err  = '0;
        do_reset();

        tv[0] = '{mk(2, 5, 'h1000, 3, K_NONE, 0), 4'b0100, 4'b0000};
        tv[1] = '{mk(1, 3, 'h2000, 1, K_RESP, 1), 4'b0010, 4'b0010};
        tv[2] = '{mk(3, 7, 'h3000, 3, K_EARLY, 1), 4'b1000, 4'b1000};
        tv[3] = '{mk(0, 1, 'h4000, 2, K_NONE, 0), 4'b0001, 4'b0000};
        tv[4] = '{mk(2, 9, 'h5000, 0, K_ID, 0), 4'b0100, 4'b0100};
        tv[5] = '{mk(1, 2, 'h6000, 2, K_MISS, 2), 4'b0010, 4'b0010};
        tv[6] = '{mk(0, 0, 'h7000, 0, K_NONE, 0), 4'b0001, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            got_done = '0;
            got_err  = '0;
            send_q.push_back(tv[i].r);
            run_idle(200);
            chk($sformatf("tv%0d_done", i), got_done, tv[i].done);
            chk($sformatf("tv%0d_err", i), got_err, tv[i].err);
        end

        // AR held off by the slave: the single AR slot blocks new requests
        p_ar = 0;
        send_q.push_back(mk(1, 4, 'h8000, 1, K_NONE, 0));
        send_q.push_back(mk(3, 6, 'h9000, 0, K_NONE, 0));
        repeat (4) cycle();
        chk("hold_arvalid", m_arvalid_o, 1);
        chk("hold_araddr", m_araddr_o, 32'h8000);
        chk("hold_rdy", atx_rdy, 0);
        p_ar = 100;
        run_idle(200);

        // Outstanding FIFO fills with no R traffic; first pop reopens it
        p_rv = 0;
        for (int i = 0; i < 5; i++) send_q.push_back(mk(i % 4, i, 'hC000 + i * 'h100, 1, K_NONE, 0));
        repeat (8) cycle();
        chk("full_rdy", atx_rdy, 0);
        chk("full_arvalid", m_arvalid_o, 0);
        p_rv = 100;
        got_done = '0;
        n = 0;
        while (got_done == '0 && n < 50) begin
            cycle();
            n++;
        end
        chk("full_first_done", got_done, 4'b0001);
        chk("refill_rdy", atx_rdy, 1);
        run_idle(300);

        // Buffer ready toggling every cycle on an 8-beat burst
        tog   = 1'b1;
        beats = 0;
        got_done = '0;
        send_q.push_back(mk(2, 3, 'hA000, 7, K_NONE, 0));
        run_idle(200);
        tog = 1'b0;
        chk("tog_beats", beats, 8);
        chk("tog_done", got_done, 4'b0100);

        // Reset in the middle of a burst, then a clean burst
        send_q.push_back(mk(2, 5, 'hB000, 3, K_NONE, 0));
        n = 0;
        while (bidx < 2 && n < 100) begin
            cycle();
            n++;
        end
        do_reset();
        got_done = '0;
        got_err  = '0;
        send_q.push_back(mk(1, 8, 'hD000, 2, K_NONE, 0));
        run_idle(200);
        chk("post_rst_done", got_done, 4'b0010);
        chk("post_rst_err", got_err, 4'b0000);

        // Random bursts: first at full throughput, then with random stalls
        for (int ph = 0; ph < 2; ph++) begin
            p_vld = (ph == 0) ? 100 : 70;
            p_ar  = (ph == 0) ? 100 : 60;
            p_rdy = (ph == 0) ? 100 : 65;
            p_rv  = (ph == 0) ? 100 : 70;
            for (int i = 0; i < 150; i++) begin
                k = $urandom_range(0, 7);
                if (k > K_MISS) k = K_NONE;
                l = $urandom_range(0, 15);
                if (k == K_EARLY && l == 0) k = K_NONE;
                if (k == K_EARLY) e = $urandom_range(0, l - 1);
                else if (k == K_MISS) e = l;
                else e = $urandom_range(0, l);
                send_q.push_back(mk($urandom_range(0, 3), $urandom, $urandom, l, k, e));
            end
            run_idle(20000);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
